ram_fifo_ctrl: RTL and testbench



---
 rtl/ram_fifo_ctrl.sv | 67 ++++++
 tb/tb_ram_fifo_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for the 16x8 dual_port_ram: wrap-bit pointers, occupancy,
// sticky error flags and a read-valid strobe aligned with the RAM's registered output.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic                  ram_we,
    output logic [ADDR_WIDTH:0]   ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_re,
    output logic [ADDR_WIDTH:0]   ram_rd_addr,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic                push_ok;
    logic                pop_ok;
    logic                clear;

    assign clear = reset | flush;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                   (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    assign count = wptr - rptr;

    // Strobes presented during reset/flush are dropped, so the RAM is not written or read.
    assign push_ok = push & ~full  & ~clear;
    assign pop_ok  = pop  & ~empty & ~clear;

    assign ram_we      = push_ok;
    assign ram_wr_addr = {1'b0, wptr[ADDR_WIDTH-1:0]};
    assign ram_din     = din;
    assign ram_re      = pop_ok;
    assign ram_rd_addr = {1'b0, rptr[ADDR_WIDTH-1:0]};

    always_ff @(posedge clock) begin
        if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            rvalid    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr   <= wptr + (ADDR_WIDTH+1)'(push_ok);
            rptr   <= rptr + (ADDR_WIDTH+1)'(pop_ok);
            rvalid <= pop_ok;
            if (push && full)
                overflow <= 1'b1;
            if (pop && empty)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 16x8 RAM (registered read)
// attached to its RAM ports.
module tb_ram_fifo_ctrl;

    logic       clock;
    logic       reset;
    logic       flush;
    logic       push;
    logic [7:0] din;
    logic       pop;
    logic       ram_we;
    logic [4:0] ram_wr_addr;
    logic [7:0] ram_din;
    logic       ram_re;
    logic [4:0] ram_rd_addr;
    logic       rvalid;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    logic [7:0] mem [0:31];
    logic [7:0] data_out;

    int passed = 0;
    int total  = 0;

    ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .push        (push),
        .din         (din),
        .pop         (pop),
        .ram_we      (ram_we),
        .ram_wr_addr (ram_wr_addr),
        .ram_din     (ram_din),
        .ram_re      (ram_re),
        .ram_rd_addr (ram_rd_addr),
        .rvalid      (rvalid),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    always_ff @(posedge clock) begin
        if (ram_we)
            mem[ram_wr_addr] <= ram_din;
        if (ram_re)
            data_out <= mem[ram_rd_addr];
    end

    // Advance past the next rising edge plus hold time; inputs may change afterwards.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic apply_reset();
        reset = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_words(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            push = 1'b1; din = base + 8'(i);
            tick();
        end
        push = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; din = 8'h00;
        for (int i = 0; i < 3; i++) begin
            push = i[0]; pop = ~i[0];
            #1;
            total++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we got=%b exp=0", ram_we); else passed++;
            total++; if (ram_re !== 1'b0) $display("FAIL reset_ram_re got=%b exp=0", ram_re); else passed++;
            tick();
        end
        reset = 1'b0; push = 1'b0; pop = 1'b0;
        #1;
        total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else passed++;
        total++; if (count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
        total++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", rvalid); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else passed++;
        total++; if (underflow !== 1'b0) $display("FAIL reset_underflow got=%b exp=0", underflow); else passed++;
        total++; if (ram_wr_addr !== 5'd0) $display("FAIL reset_wr_addr got=%0d exp=0", ram_wr_addr); else passed++;
        total++; if (ram_rd_addr !== 5'd0) $display("FAIL reset_rd_addr got=%0d exp=0", ram_rd_addr); else passed++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; din = 8'(i);
            #1;
            total++; if (ram_we !== 1'b1) $display("FAIL fill_we[%0d] got=%b exp=1", i, ram_we); else passed++;
            total++; if (ram_wr_addr !== 5'(i)) $display("FAIL fill_addr[%0d] got=%0d exp=%0d", i, ram_wr_addr, i); else passed++;
            total++; if (ram_din !== 8'(i)) $display("FAIL fill_din[%0d] got=%h exp=%h", i, ram_din, 8'(i)); else passed++;
            tick();
        end
        push = 1'b0;
        #1;
        total++; if (full !== 1'b1) $display("FAIL fill_full got=%b exp=1", full); else passed++;
        total++; if (count !== 5'd16) $display("FAIL fill_count got=%0d exp=16", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL fill_no_overflow got=%b exp=0", overflow); else passed++;
        push = 1'b1; din = 8'hAA;
        #1;
        total++; if (ram_we !== 1'b0) $display("FAIL ovf_we got=%b exp=0", ram_we); else passed++;
        tick();
        push = 1'b0;
        #1;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow); else passed++;
        total++; if (count !== 5'd16) $display("FAIL ovf_count got=%0d exp=16", count); else passed++;
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 16; i++) begin
            pop = 1'b1;
            #1;
            total++; if (ram_re !== 1'b1) $display("FAIL drain_re[%0d] got=%b exp=1", i, ram_re); else passed++;
            total++; if (ram_rd_addr !== 5'(i)) $display("FAIL drain_addr[%0d] got=%0d exp=%0d", i, ram_rd_addr, i); else passed++;
            tick();
            total++; if (rvalid !== 1'b1) $display("FAIL drain_rvalid[%0d] got=%b exp=1", i, rvalid); else passed++;
            total++; if (data_out !== 8'(i)) $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_out, 8'(i)); else passed++;
        end
        total++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", empty); else passed++;
        total++; if (count !== 5'd0) $display("FAIL drain_count got=%0d exp=0", count); else passed++;
        #1;
        total++; if (ram_re !== 1'b0) $display("FAIL udf_re got=%b exp=0", ram_re); else passed++;
        tick();
        pop = 1'b0;
        #1;
        total++; if (underflow !== 1'b1) $display("FAIL udf_flag got=%b exp=1", underflow); else passed++;
        total++; if (rvalid !== 1'b0) $display("FAIL udf_rvalid got=%b exp=0", rvalid); else passed++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        push_words(5, 8'h10);
        for (int k = 0; k < 20; k++) begin
            push = 1'b1; pop = 1'b1; din = 8'h15 + 8'(k);
            #1;
            total++; if (ram_wr_addr !== 5'((5 + k) % 16)) $display("FAIL sim_wr_addr[%0d] got=%0d exp=%0d", k, ram_wr_addr, (5 + k) % 16); else passed++;
            total++; if (ram_rd_addr !== 5'(k % 16)) $display("FAIL sim_rd_addr[%0d] got=%0d exp=%0d", k, ram_rd_addr, k % 16); else passed++;
            tick();
            total++; if (data_out !== 8'h10 + 8'(k) || rvalid !== 1'b1) $display("FAIL sim_data[%0d] got=%h/%b exp=%h/1", k, data_out, rvalid, 8'h10 + 8'(k)); else passed++;
            total++; if (count !== 5'd5) $display("FAIL sim_count[%0d] got=%0d exp=5", k, count); else passed++;
        end
        pop = 1'b0;
        push_words(11, 8'h40);
        #1;
        total++; if (full !== 1'b1) $display("FAIL simfull_full got=%b exp=1", full); else passed++;
        push = 1'b1; pop = 1'b1; din = 8'hEE;
        #1;
        total++; if (ram_we !== 1'b0) $display("FAIL simfull_we got=%b exp=0", ram_we); else passed++;
        total++; if (ram_re !== 1'b1) $display("FAIL simfull_re got=%b exp=1", ram_re); else passed++;
        tick();
        push = 1'b0; pop = 1'b0;
        #1;
        total++; if (count !== 5'd15) $display("FAIL simfull_count got=%0d exp=15", count); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL simfull_overflow got=%b exp=1", overflow); else passed++;
        total++; if (data_out !== 8'h24 || rvalid !== 1'b1) $display("FAIL simfull_data got=%h/%b exp=24/1", data_out, rvalid); else passed++;
    endtask

    task automatic test_empty_push_pop();
        apply_reset();
        push = 1'b1; pop = 1'b1; din = 8'h3C;
        #1;
        total++; if (ram_we !== 1'b1) $display("FAIL epp_we got=%b exp=1", ram_we); else passed++;
        total++; if (ram_re !== 1'b0) $display("FAIL epp_re got=%b exp=0", ram_re); else passed++;
        tick();
        push = 1'b0; pop = 1'b0;
        #1;
        total++; if (count !== 5'd1) $display("FAIL epp_count got=%0d exp=1", count); else passed++;
        total++; if (underflow !== 1'b1) $display("FAIL epp_underflow got=%b exp=1", underflow); else passed++;
        total++; if (rvalid !== 1'b0) $display("FAIL epp_rvalid got=%b exp=0", rvalid); else passed++;
    endtask

    task automatic test_flush();
        apply_reset();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        push_words(17, 8'h80);
        for (int i = 0; i < 7; i++) begin
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        #1;
        total++; if (count !== 5'd9 || overflow !== 1'b1 || underflow !== 1'b1) $display("FAIL flush_setup got=%0d/%b/%b exp=9/1/1", count, overflow, underflow); else passed++;
        flush = 1'b1; push = 1'b1; pop = 1'b1; din = 8'h77;
        #1;
        total++; if (ram_we !== 1'b0 || ram_re !== 1'b0) $display("FAIL flush_strobes got=%b/%b exp=0/0", ram_we, ram_re); else passed++;
        tick();
        flush = 1'b0; push = 1'b0; pop = 1'b0;
        #1;
        total++; if (count !== 5'd0) $display("FAIL flush_count got=%0d exp=0", count); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL flush_empty got=%b exp=1", empty); else passed++;
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL flush_flags got=%b/%b exp=0/0", overflow, underflow); else passed++;
        total++; if (rvalid !== 1'b0) $display("FAIL flush_rvalid got=%b exp=0", rvalid); else passed++;
        push = 1'b1; din = 8'h5C;
        tick();
        push = 1'b0; pop = 1'b1;
        tick();
        pop = 1'b0;
        total++; if (rvalid !== 1'b1) $display("FAIL flush_post_rvalid got=%b exp=1", rvalid); else passed++;
        total++; if (data_out !== 8'h5C) $display("FAIL flush_post_data got=%h exp=5c", data_out); else passed++;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_empty_push_pop();
        test_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
